display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Upstream feeder for the per-digit seven-segment driver.
- Accepts a 14-bit binary value on a load strobe and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine, one bit per cycle.
- Holds the last converted result and time-multiplexes it onto the `select`/`digit_val` pair the digit driver consumes, rotating through digits 0..3 at a programmable refresh rate.

Parameters:
- REFRESH_DIV, 100000, src_clk cycles each digit is held before `select` advances (1 kHz per digit at 100 MHz); legal range 2..2^CNT_W.
- CNT_W, 17, width of the refresh prescaler; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- src_clk  input  1  system clock, all logic on rising edge.
- src_rst  input  1  reset, synchronous, active-high.
- value_in  input  14  binary value to display (0..16383).
- load  input  1  single-cycle strobe; samples `value_in` when block is idle.
- busy  output  1  high while a conversion is in progress.
- bcd_out  output  16  committed display value, four BCD nibbles; [3:0] is digit 0 (units).
- select  output  2  digit currently scanned; feeds the digit driver's `select`.
- digit_val  output  4  BCD nibble for the current `select`; feeds the driver's `digit_val`.

Behaviour:
- Reset (src_rst=1 at a clock edge): state=IDLE, busy=0, bcd_out=16'h0000, select=0, prescaler=0, shift register cleared. A conversion in flight is abandoned and `bcd_out` does not change to a partial result.
- FSM states: IDLE, CONV.
  - IDLE: if load=1, capture `value_in` into the binary shift register, clear the 20-bit BCD accumulator, clear the bit counter, and go to CONV. Otherwise stay in IDLE.
  - CONV: each cycle, add 3 to every accumulator nibble >= 5, then shift {accumulator, binary} left by one, all in a single cycle. Increment the bit counter.
  - CONV exit: on the 14th shift (counter==13), commit the result to `bcd_out` and return to IDLE.
- busy = (state==CONV), registered.
- Latency:
  - A load sampled at edge k raises `busy` after edge k.
  - Shifts occur on edges k+1..k+14.
  - `bcd_out` takes the new value and `busy` falls after edge k+14.
  - A new load is accepted at edge k+15 at the earliest.
- Load while busy: ignored; no queuing. `value_in` is sampled only on an accepted load.
- Width rule: the accumulator holds 5 BCD digits (max 16383). `bcd_out` takes the low four digits, so the displayed value is value mod 10000 unless the optional feature is enabled.
- Scan prescaler:
  - Counts 0..REFRESH_DIV-1 continuously, independent of conversion.
  - At terminal count it wraps to 0 and `select` advances 0→1→2→3→0.
- digit_val: combinational mux of registered `select` and `bcd_out` (select=n gives bcd_out[4n+3:4n]).
  - The downstream driver registers it, so `select` and `digit_val` are always mutually consistent in the same cycle.
  - A commit to `bcd_out` mid-dwell is reflected immediately on `digit_val`.
- Simultaneous load and refresh tick: independent; both take effect.
- load held high continuously: a new conversion starts every 15 cycles.

Optional Feature:
- Macro: SCORE_SATURATE_EN.
- Defined: on an accepted load, any `value_in` > 9999 is replaced by 9999 before conversion, so `bcd_out` reads 16'h9999.
- Undefined: no clamp; the ten-thousands digit is discarded (12345 displays 2345).
- Latency and handshake are identical in both builds.

Test Plan:
- Reset then load `value_in`=1234 → busy high for exactly 14 cycles; bcd_out=16'h1234 after edge k+14; busy=0 next cycle.
- Loads of 0, 9, 10, 99, 9999 in sequence, each after busy falls → bcd_out = 16'h0000, 0009, 0010, 0099, 9999.
- Load 12345 → bcd_out=16'h2345 without SCORE_SATURATE_EN; 16'h9999 with it. Load 16383 → 16'h6383 without the macro, 16'h9999 with it.
- Load 1234, then at cycle k+5 pulse load with value_in=5678 → second load ignored; bcd_out=16'h1234; a load of 5678 after busy falls gives 16'h5678.
- Load 4321, then assert src_rst at cycle k+7 → busy=0 and bcd_out=16'h0000 after that edge; no later commit of 4321.
- REFRESH_DIV=4, bcd_out=16'h4321 → select steps 0,1,2,3,0 every 4 cycles; digit_val reads 1,2,3,4,1 in lockstep with select.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 4-digit scan multiplexer.
// Optional build macro SCORE_SATURATE_EN clamps loaded values above 9999 to 9999.
module display_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic        src_clk,
    input  logic        src_rst,
    input  logic [13:0] value_in,
    input  logic        load,
    output logic        busy,
    output logic [15:0] bcd_out,
    output logic [1:0]  select,
    output logic [3:0]  digit_val
);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [3:0]       LAST_BIT   = 4'd13;

    state_t      state;
    state_t      next_state;
    logic [13:0] bin_sr;
    logic [13:0] bin_next;
    logic [13:0] load_val;
    logic [19:0] acc;
    logic [19:0] acc_adj;
    logic [19:0] acc_next;
    logic [33:0] shifted;
    logic [3:0]  bit_cnt;
    logic        capture;
    logic        shift;
    logic        commit;
    logic [CNT_W-1:0] presc;

    always_comb begin
`ifdef SCORE_SATURATE_EN
        load_val = (value_in > 14'd9999) ? 14'd9999 : value_in;
`else
        load_val = value_in;
`endif
    end

    // Add-3 correction and the one-bit shift happen in the same cycle.
    always_comb begin
        acc_adj = acc;
        for (int unsigned i = 0; i < 5; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        shifted  = {acc_adj, bin_sr} << 1;
        acc_next = shifted[33:14];
        bin_next = shifted[13:0];
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        shift      = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    capture    = 1'b1;
                    next_state = CONV;
                end
            end
            CONV: begin
                shift = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    commit     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == CONV);
        end
    end

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            bin_sr  <= '0;
            acc     <= '0;
            bit_cnt <= '0;
            bcd_out <= '0;
        end else if (capture) begin
            bin_sr  <= load_val;
            acc     <= '0;
            bit_cnt <= '0;
        end else if (shift) begin
            bin_sr  <= bin_next;
            acc     <= acc_next;
            bit_cnt <= bit_cnt + 4'd1;
            // Ten-thousands digit is dropped; only four digits are displayed.
            if (commit) begin
                bcd_out <= acc_next[15:0];
            end
        end
    end

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            presc  <= '0;
            select <= '0;
        end else if (presc == PRESC_LAST) begin
            presc  <= '0;
            select <= select + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        digit_val = '0;
        case (select)
            2'd0: digit_val = bcd_out[3:0];
            2'd1: digit_val = bcd_out[7:4];
            2'd2: digit_val = bcd_out[11:8];
            2'd3: digit_val = bcd_out[15:12];
            default: digit_val = '0;
        endcase
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: table-driven conversions with a scoreboard,
// plus hand-written sequences for ignored loads, mid-conversion reset, held load and scanning.
module tb_display_scan_ctrl;

    logic        src_clk = 1'b0;
    logic        src_rst = 1'b1;
    logic [13:0] value_in = '0;
    logic        load = 1'b0;
    logic        busy;
    logic [15:0] bcd_out;
    logic [1:0]  select;
    logic [3:0]  digit_val;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] sb[$];

    typedef struct {
        logic [13:0] value;
        logic [15:0] expect_bcd;
    } vec_t;

    vec_t vecs[8];

    display_scan_ctrl #(
        .REFRESH_DIV(4),
        .CNT_W(3)
    ) dut (
        .src_clk(src_clk),
        .src_rst(src_rst),
        .value_in(value_in),
        .load(load),
        .busy(busy),
        .bcd_out(bcd_out),
        .select(select),
        .digit_val(digit_val)
    );

    always #5 src_clk = ~src_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] s);
        logic [15:0] t;
        t = v >> (4 * s);
        return t[3:0];
    endfunction

    // One conversion; optionally pulses a second load poke_cycle edges after acceptance.
    task automatic run_conv(input logic [13:0] v, input logic [15:0] exp,
                            input int poke_cycle, input logic [13:0] poke_val);
        int cyc;
        logic [15:0] want;
        cyc = 0;
        @(negedge src_clk);
        load = 1'b1;
        value_in = v;
        @(posedge src_clk);
        #1;
        check("busy_rise", busy, 1);
        sb.push_back(exp);
        for (int i = 1; i <= 20; i++) begin
            @(negedge src_clk);
            load = (i == poke_cycle);
            value_in = (i == poke_cycle) ? poke_val : v;
            @(posedge src_clk);
            #1;
            if (!busy) begin
                cyc = i;
                break;
            end
        end
        @(negedge src_clk);
        load = 1'b0;
        check("busy_len", cyc, 14);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            want = sb.pop_front();
            check("bcd_out", bcd_out, want);
            check("digit_val_commit", digit_val, nib(want, select));
        end
    endtask

    initial begin
        automatic logic [15:0] scan_bcd = 16'h4321;
        automatic logic [1:0]  s0;
        automatic bit          found;

        vecs[0] = '{14'd1234, 16'h1234};
        vecs[1] = '{14'd0,    16'h0000};
        vecs[2] = '{14'd9,    16'h0009};
        vecs[3] = '{14'd10,   16'h0010};
        vecs[4] = '{14'd99,   16'h0099};
        vecs[5] = '{14'd9999, 16'h9999};
`ifdef SCORE_SATURATE_EN
        vecs[6] = '{14'd12345, 16'h9999};
        vecs[7] = '{14'd16383, 16'h9999};
`else
        vecs[6] = '{14'd12345, 16'h2345};
        vecs[7] = '{14'd16383, 16'h6383};
`endif

        repeat (3) @(posedge src_clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_bcd", bcd_out, 16'h0000);
        check("rst_select", select, 0);
        check("rst_digit", digit_val, 0);
        @(negedge src_clk);
        src_rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_conv(vecs[i].value, vecs[i].expect_bcd, 0, '0);
        end

        // Second load arriving mid-conversion must be ignored.
        run_conv(14'd1234, 16'h1234, 5, 14'd5678);
        run_conv(14'd5678, 16'h5678, 0, '0);

        // Reset during conversion abandons it without committing.
        @(negedge src_clk);
        load = 1'b1;
        value_in = 14'd4321;
        @(posedge src_clk);
        #1;
        check("rst_mid_busy_rise", busy, 1);
        for (int i = 1; i <= 7; i++) begin
            @(negedge src_clk);
            load = 1'b0;
            src_rst = (i == 7);
            @(posedge src_clk);
            #1;
        end
        check("rst_mid_busy", busy, 0);
        check("rst_mid_bcd", bcd_out, 16'h0000);
        check("rst_mid_select", select, 0);
        @(negedge src_clk);
        src_rst = 1'b0;
        repeat (20) @(posedge src_clk);
        #1;
        check("rst_no_commit_bcd", bcd_out, 16'h0000);
        check("rst_no_commit_busy", busy, 0);

        // Held load restarts a conversion every 15 cycles.
        @(negedge src_clk);
        load = 1'b1;
        value_in = 14'd42;
        @(posedge src_clk);
        #1;
        check("hold_busy_rise", busy, 1);
        repeat (14) @(posedge src_clk);
        #1;
        check("hold_busy_fall", busy, 0);
        check("hold_bcd", bcd_out, 16'h0042);
        @(posedge src_clk);
        #1;
        check("hold_restart", busy, 1);
        @(negedge src_clk);
        load = 1'b0;
        repeat (14) @(posedge src_clk);
        #1;
        check("hold_second_done", busy, 0);

        // Scan: select advances every 4 cycles with digit_val in lockstep.
        run_conv(14'd4321, scan_bcd, 0, '0);
        s0 = select;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge src_clk);
            #1;
            if (select != s0) begin
                found = 1'b1;
                break;
            end
        end
        check("scan_sync", found, 1);
        s0 = select;
        for (int step = 0; step < 5; step++) begin
            for (int c = 0; c < 4; c++) begin
                check("scan_select", select, 2'(s0 + 2'(step)));
                check("scan_digit", digit_val, nib(scan_bcd, 2'(s0 + 2'(step))));
                @(posedge src_clk);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
